// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_arb_pkg
// Description : Shared constants and the round-robin pick function.
// Revision    : 1.0
// ============================================================================
package mux_arb_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int DATA_W_DEF = 8;

  // rr_pick scans at most MAX_REQ requesters, so arbiters are limited to 32 inputs.
  localparam int MAX_REQ = 32;
  localparam int IDX_W   = 5;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] vld,
                                       input logic [IDX_W-1:0]   ptr,
                                       input int                 n);
    rr_pick_t       r;
    logic [IDX_W:0] idx;
    r = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        // ptr < n and k < n, so one conditional subtract is enough for the wrap.
        idx = {1'b0, ptr} + (IDX_W+1)'(k);
        if (idx >= (IDX_W+1)'(n)) idx = idx - (IDX_W+1)'(n);
        if (!r.found && vld[idx[IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = idx[IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux.sv
`default_nettype none
// ============================================================================
// Module      : mux
// Description : 2:1 word multiplexer cell.
// Revision    : 1.0
// ============================================================================
module mux #(
  parameter int W = 8
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = sel ? in1 : in0;

endmodule
`default_nettype wire

// File: rtl/mux_n.sv
`default_nettype none
// ============================================================================
// Module      : mux_n
// Description : N:1 combinational word mux built as a binary tree of 2:1 cells.
// Revision    : 1.0
// ============================================================================
module mux_n #(
  parameter  int N     = 4,
  parameter  int W     = 8,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N*W-1:0]   din,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     dout
);

  localparam int NLEAF = 1 << SEL_W;

  // Heap layout: node i has children 2i+1 / 2i+2, leaves start at NLEAF-1.
  logic [W-1:0] w_node [0:2*NLEAF-2];

  for (genvar j = 0; j < NLEAF; j++) begin : g_leaf
    if (j < N) begin : g_real
      assign w_node[NLEAF-1+j] = din[j*W +: W];
    end else begin : g_pad
      assign w_node[NLEAF-1+j] = '0;
    end
  end

  for (genvar d = 0; d < SEL_W; d++) begin : g_lvl
    for (genvar k = 0; k < (1 << d); k++) begin : g_node
      localparam int I = (1 << d) - 1 + k;
      mux #(.W(W)) u_mux (
        .in0 (w_node[2*I+1]),
        .in1 (w_node[2*I+2]),
        .sel (sel[SEL_W-1-d]),
        .y   (w_node[I])
      );
    end
  end

  assign dout = w_node[0];

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Round-robin valid/ready arbiter feeding a registered output.
// Revision    : 1.0
// ============================================================================
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int N_REQ  = N_REQ_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int SRC_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_vld,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_rdy,
  output logic                    out_vld,
  output logic [DATA_W-1:0]       out_data,
  output logic [SRC_W-1:0]        out_src,
  input  logic                    out_rdy
);

  logic [SRC_W-1:0]  r_ptr;
  rr_pick_t          w_pick;
  logic              w_load_en;
  logic              w_grant;
  logic [SRC_W-1:0]  w_g;
  logic [DATA_W-1:0] w_mux;

  assign w_pick    = rr_pick(MAX_REQ'(req_vld), IDX_W'(r_ptr), N_REQ);
  assign w_g       = SRC_W'(w_pick.idx);
  assign w_load_en = !out_vld || out_rdy;
  // rst_n gates the grant so no handshake can be offered while reset is held.
  assign w_grant   = rst_n && w_load_en && w_pick.found;

  always_comb begin
    req_rdy = '0;
    if (w_grant) req_rdy[w_g] = 1'b1;
  end

  mux_n #(.N(N_REQ), .W(DATA_W)) u_mux_n (
    .din  (req_data),
    .sel  (w_g),
    .dout (w_mux)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_src  <= '0;
      r_ptr    <= '0;
    end else if (w_load_en) begin
      if (w_grant) begin
        out_vld  <= 1'b1;
        out_data <= w_mux;
        out_src  <= w_g;
        r_ptr    <= (w_g == SRC_W'(N_REQ-1)) ? '0 : w_g + SRC_W'(1);
      end else begin
        out_vld  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_arbiter
// Description : Self-checking bench for mux_rr_arbiter (N_REQ=4 and N_REQ=3).
// Revision    : 1.0
// ============================================================================
module tb_mux_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic [3:0]  vld4, rdy4;
  logic [31:0] data4;
  logic        ovld4, ordy4;
  logic [7:0]  odata4;
  logic [1:0]  osrc4;

  logic [2:0]  vld3, rdy3;
  logic [23:0] data3;
  logic        ovld3, ordy3;
  logic [7:0]  odata3;
  logic [1:0]  osrc3;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the 4-requester instance.
  bit         m_vld;
  logic [7:0] m_data;
  int         m_src, m_ptr;

  mux_rr_arbiter #(.N_REQ(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_vld(vld4), .req_data(data4), .req_rdy(rdy4),
    .out_vld(ovld4), .out_data(odata4), .out_src(osrc4), .out_rdy(ordy4)
  );

  mux_rr_arbiter #(.N_REQ(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_vld(vld3), .req_data(data3), .req_rdy(rdy3),
    .out_vld(ovld3), .out_data(odata3), .out_src(osrc3), .out_rdy(ordy3)
  );

  function automatic int model_grant();
    if (m_vld && !ordy4) return -1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (vld4[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_rdy();
    int g;
    g = model_grant();
    return (g < 0) ? 4'b0000 : 4'(1 << g);
  endfunction

  task automatic model_reset();
    m_vld = 0; m_data = 8'h00; m_src = 0; m_ptr = 0;
  endtask

  // Advance one clock edge and the model with it; returns at edge + 1.
  task automatic tick();
    int g;
    bit le;
    g  = model_grant();
    le = !m_vld || ordy4;
    @(posedge clk);
    if (le) begin
      if (g >= 0) begin
        m_vld = 1; m_data = data4[g*8 +: 8]; m_src = g; m_ptr = (g + 1) % 4;
      end else begin
        m_vld = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    vld4 = 4'b1111;
    #2;
    n_checks++;
    if (rdy4 !== 4'b0000 || ovld4 !== 1'b0 || osrc4 !== 2'd0 || odata4 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_init: rdy=%b vld=%b src=%0d data=%h, expected 0000/0/0/00", rdy4, ovld4, osrc4, odata4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    ordy4 = 1'b0;
    tick();
    tick();
    n_checks++;
    if (ovld4 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prefill: out_vld=%b expected 1", ovld4);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rdy4 !== 4'b0000 || ovld4 !== 1'b0 || osrc4 !== 2'd0 || odata4 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid: rdy=%b vld=%b src=%0d data=%h, expected 0000/0/0/00", rdy4, ovld4, osrc4, odata4);
    end
    model_reset();
    vld4  = 4'b0100;
    ordy4 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (rdy4 !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_first_rdy: got %b expected 0100", rdy4);
    end
    tick();
    n_checks++;
    if (ovld4 !== 1'b1 || osrc4 !== 2'd2 || odata4 !== data4[23:16]) begin
      n_fail++;
      $display("FAIL reset_first_grant: vld=%b src=%0d data=%h expected 1/2/%h", ovld4, osrc4, odata4, data4[23:16]);
    end
  endtask

  task automatic test_single();
    vld4 = 4'b0010;
    data4[15:8] = 8'hA5;
    ordy4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (rdy4 !== 4'b0010) begin
        n_fail++;
        $display("FAIL single_rdy: got %b expected 0010", rdy4);
      end
      tick();
      n_checks++;
      if (ovld4 !== 1'b1 || odata4 !== 8'hA5 || osrc4 !== 2'd1) begin
        n_fail++;
        $display("FAIL single_out: vld=%b data=%h src=%0d expected 1/a5/1", ovld4, odata4, osrc4);
      end
    end
  endtask

  task automatic test_all();
    int prev, exp_g;
    vld4  = 4'b1111;
    ordy4 = 1'b1;
    prev  = int'(osrc4);
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_g = model_grant();
      n_checks++;
      if (rdy4 !== model_rdy()) begin
        n_fail++;
        $display("FAIL all_rdy: got %b expected %b", rdy4, model_rdy());
      end
      tick();
      n_checks++;
      if (ovld4 !== 1'b1 || osrc4 !== 2'((prev + 1) % 4) || osrc4 !== 2'(exp_g) || odata4 !== m_data) begin
        n_fail++;
        $display("FAIL all_seq: vld=%b src=%0d data=%h expected 1/%0d/%h", ovld4, osrc4, odata4, exp_g, m_data);
      end
      prev = int'(osrc4);
      data4[exp_g*8 +: 8] = 8'($urandom);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] s_data;
    logic [1:0] s_src;
    vld4  = 4'b1111;
    ordy4 = 1'b1;
    tick();
    ordy4  = 1'b0;
    s_data = odata4;
    s_src  = osrc4;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (rdy4 !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_rdy: got %b expected 0000", rdy4);
      end
      tick();
      n_checks++;
      if (ovld4 !== 1'b1 || odata4 !== s_data || osrc4 !== s_src) begin
        n_fail++;
        $display("FAIL bp_hold: vld=%b data=%h src=%0d expected 1/%h/%0d", ovld4, odata4, osrc4, s_data, s_src);
      end
    end
    ordy4 = 1'b1;
    #1;
    n_checks++;
    if (rdy4 !== 4'(1 << ((int'(s_src) + 1) % 4))) begin
      n_fail++;
      $display("FAIL bp_release_rdy: got %b expected %b", rdy4, 4'(1 << ((int'(s_src) + 1) % 4)));
    end
    tick();
    n_checks++;
    if (ovld4 !== 1'b1 || osrc4 !== 2'((int'(s_src) + 1) % 4) || odata4 !== m_data) begin
      n_fail++;
      $display("FAIL bp_release_out: vld=%b src=%0d data=%h expected 1/%0d/%h", ovld4, osrc4, odata4, (int'(s_src) + 1) % 4, m_data);
    end
  endtask

  task automatic test_sparse();
    ordy4 = 1'b1;
    vld4  = 4'b0001;
    tick();
    vld4 = 4'b1001;
    #1;
    n_checks++;
    if (rdy4 !== 4'b1000) begin
      n_fail++;
      $display("FAIL sparse_rdy3: got %b expected 1000", rdy4);
    end
    tick();
    n_checks++;
    if (osrc4 !== 2'd3 || odata4 !== data4[31:24]) begin
      n_fail++;
      $display("FAIL sparse_src3: src=%0d data=%h expected 3/%h", osrc4, odata4, data4[31:24]);
    end
    #1;
    n_checks++;
    if (rdy4 !== 4'b0001) begin
      n_fail++;
      $display("FAIL sparse_rdy0: got %b expected 0001", rdy4);
    end
    tick();
    n_checks++;
    if (osrc4 !== 2'd0 || odata4 !== data4[7:0]) begin
      n_fail++;
      $display("FAIL sparse_src0: src=%0d data=%h expected 0/%h", osrc4, odata4, data4[7:0]);
    end
    vld4 = 4'b0000;
    tick();
    n_checks++;
    if (ovld4 !== 1'b0 || osrc4 !== 2'd0 || odata4 !== data4[7:0]) begin
      n_fail++;
      $display("FAIL idle_keep: vld=%b src=%0d data=%h expected 0/0/%h", ovld4, osrc4, odata4, data4[7:0]);
    end
  endtask

  task automatic test_wrap3();
    vld3  = 3'b111;
    data3 = {8'h33, 8'h22, 8'h11};
    ordy3 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      n_checks++;
      if (rdy3 !== 3'(1 << (i % 3))) begin
        n_fail++;
        $display("FAIL wrap3_rdy: got %b expected %b", rdy3, 3'(1 << (i % 3)));
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (ovld3 !== 1'b1 || osrc3 !== 2'(i % 3) || odata3 !== data3[(i % 3)*8 +: 8]) begin
        n_fail++;
        $display("FAIL wrap3_out: vld=%b src=%0d data=%h expected 1/%0d/%h", ovld3, osrc3, odata3, i % 3, data3[(i % 3)*8 +: 8]);
      end
    end
    vld3 = 3'b000;
  endtask

  task automatic test_random();
    int         wait_cnt [4];
    int         gi, worst;
    logic [3:0] rdy_obs;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    vld4 = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!vld4[i] && $urandom_range(1) == 1) begin
          vld4[i] = 1'b1;
          data4[i*8 +: 8] = 8'($urandom);
        end
      end
      ordy4 = ($urandom_range(3) != 0);
      #1;
      rdy_obs = rdy4;
      n_checks++;
      if (rdy_obs !== model_rdy()) begin
        n_fail++;
        $display("FAIL rand_rdy: cycle %0d got %b expected %b", c, rdy_obs, model_rdy());
      end
      tick();
      n_checks++;
      if (ovld4 !== m_vld || osrc4 !== 2'(m_src) || odata4 !== m_data) begin
        n_fail++;
        $display("FAIL rand_out: cycle %0d vld=%b src=%0d data=%h expected %b/%0d/%h", c, ovld4, osrc4, odata4, m_vld, m_src, m_data);
      end
      gi = -1;
      for (int i = 0; i < 4; i++) if (rdy_obs[i]) gi = i;
      worst = 0;
      if (gi >= 0) begin
        for (int i = 0; i < 4; i++) begin
          if (i == gi) begin
            wait_cnt[i] = 0;
            vld4[i] = 1'b0;
          end else if (vld4[i]) begin
            wait_cnt[i]++;
          end
        end
      end
      for (int i = 0; i < 4; i++) if (wait_cnt[i] > worst) worst = wait_cnt[i];
      n_checks++;
      if (worst > 3) begin
        n_fail++;
        $display("FAIL rand_fairness: cycle %0d a requester waited %0d grants, expected at most 3", c, worst);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    vld4  = 4'b0000; data4 = 32'($urandom); ordy4 = 1'b0;
    vld3  = 3'b000;  data3 = 24'h000000;    ordy3 = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_all();
    test_backpressure();
    test_sparse();
    test_wrap3();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one N-to-1 data multiplexer between `N_REQ` valid/ready requesters and drives a single registered output channel. It picks one requester per accepted transfer, steers that requester's data through the shared mux into a one-entry output register, and advances a fairness pointer. It is the scheduler placed in front of any shared mux-based datapath in the design.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, ≥2, need not be a power of two.
- `DATA_W`, default 8: payload width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset. Asynchronous assert, active-low.
- `req_vld`  in  N_REQ: per-requester valid.
- `req_data`  in  N_REQ×DATA_W: per-requester payload, packed, index i at bits [i*DATA_W +: DATA_W].
- `req_rdy`  out  N_REQ: per-requester ready. One-hot or zero.
- `out_vld`  out  1: output register holds a transfer.
- `out_data`  out  DATA_W: registered payload.
- `out_src`  out  SRC_W = max(1,$clog2(N_REQ)): index of the requester that supplied `out_data`.
- `out_rdy`  in  1: downstream accepts.

## Operation
- State: output register (`out_vld`, `out_data`, `out_src`) and priority pointer `ptr`, range 0..N_REQ-1.
- `load_en = !out_vld || out_rdy`. The register is empty or is being drained this cycle.
- Grant: when `load_en` and any `req_vld` is set, `g` is the first index with `req_vld` set, scanning circularly from `ptr` through `ptr+N_REQ-1` mod N_REQ. `req_rdy[g]=1`. All other `req_rdy` bits are 0.
- `req_rdy` is combinational from `req_vld`, `ptr`, `out_vld` and `out_rdy`. No `req_rdy` bit depends on `req_data`.
- On a grant edge:
  - `out_vld<=1`
  - `out_data<=req_data[g]`
  - `out_src<=g`
  - `ptr<=(g+1)` mod N_REQ. Wrap from N_REQ-1 goes to 0, including when N_REQ is not a power of two.
- `load_en` with no requests: `out_vld<=0`. `out_data` and `out_src` keep their values. `ptr` is unchanged.
- `!load_en` (stall): the output register and `ptr` hold. All `req_rdy` bits are 0.
- Fairness: a requester that holds `req_vld` is granted within N_REQ grants.
- Requesters keep `req_vld` and `req_data` stable until they see `req_rdy`. The arbiter may move its grant to another requester on any cycle where no handshake occurs.
- Reset (any time, including mid-transfer):
  - `out_vld=0`, `out_data=0`, `out_src=0`, `ptr=0`.
  - `req_rdy` is all-zero while `rst_n=0`.
  - An in-flight output transfer is dropped.

## Timing
- Latency: a requester handshake at edge k makes the data visible on `out_*` after edge k. That is one cycle.
- Throughput: one transfer per cycle when `out_rdy` is held at 1.
- Simultaneous drain and load in the same cycle is required. There is no bubble between back-to-back transfers.
- Combinational path `out_rdy` → `req_rdy` is permitted and documented. No path exists from `req_*` to `out_*`.
- `rst_n` deassertion is synchronized externally. The first grant is allowed on the first edge with `rst_n=1`.

## Structure
- Package `mux_arb_pkg`:
  - default constants `N_REQ_DEF=4` and `DATA_W_DEF=8`
  - function `rr_pick(vld, ptr)`, which returns the grant index and a found flag.
- One sub-module, `mux_n`: a parameterized N_REQ:1 combinational mux of DATA_W-bit words, selected by `g`. It is built from the team's 2:1 `mux` cell in a binary tree. Non-power-of-two leaves are padded with constant 0.
- Top level: pointer register, grant logic and output register. The mux tree stays in `mux_n`.

## Test plan
- Reset: assert `rst_n=0` mid-stream with `out_vld=1`. Then `out_vld=0`, `out_src=0`, `req_rdy=0`. After release with `req_vld=4'b0100`, the first grant is to 2.
- Single requester: `req_vld=4'b0010`, `req_data[1]=8'hA5`, `out_rdy=1`. Then `req_rdy=4'b0010`, and `out_data=8'hA5`, `out_src=1` one cycle later, every cycle.
- All four requesting continuously, `out_rdy=1`: `out_src` sequence is 0,1,2,3,0,1…, with data matching per index and no gaps.
- Backpressure: `out_rdy=0` for 3 cycles with `out_vld=1`. Then `out_data`/`out_src` are stable, `req_rdy=0`, `ptr` is held. When `out_rdy` returns to 1, a new grant occurs in the same cycle.
- Sparse and skip: `ptr=1`, `req_vld=4'b1001` → grant to 3, then `ptr=0` → grant to 0.
- N_REQ=3 wrap: all requesting gives `out_src` 0,1,2,0. `out_src` never reaches 3.
